// File: rtl/dla_rand_pkg.sv
// Shared types and defaults for the DLA random-stimulus/response slice.
// State encoding puts busy/done on dedicated state bits.
package dla_rand_pkg;

    localparam int SIG_WIDTH_DEF = 16;
    localparam logic [15:0] SEED_DEF = 16'hACE1;
    localparam logic [15:0] POLY_DEF = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_DONE    = 2'b10
    } state_e;

endpackage

// File: rtl/dla_misr.sv
// Galois MISR signature register with synchronous load and step enable.
// Load (or reset) wins over step.
module dla_misr
    import dla_rand_pkg::*;
#(
    parameter int SIG_WIDTH = SIG_WIDTH_DEF,
    parameter logic [SIG_WIDTH-1:0] POLY = SIG_WIDTH'(POLY_DEF),
    parameter logic [SIG_WIDTH-1:0] SEED = SIG_WIDTH'(SEED_DEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [SIG_WIDTH-1:0] data,
    output logic [SIG_WIDTH-1:0] sig
);

    logic [SIG_WIDTH-1:0] fb_mask;
    logic [SIG_WIDTH-1:0] sig_next;

    // Shift left, fold the MSB back through the polynomial, inject data
    always_comb begin
        fb_mask  = sig[SIG_WIDTH-1] ? POLY : '0;
        sig_next = {sig[SIG_WIDTH-2:0], 1'b0} ^ fb_mask ^ data;
    end

    // Signature register: reseed on reset/load, advance on step
    always_ff @(posedge clk) begin
        if (rst || load) begin
            sig <= SEED;
        end else if (step) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/dla_response_compactor.sv
// Compacts DLA dummy-output beats into a MISR signature over a fixed
// window of valid beats; an idle timeout ends a stalled run.
module dla_response_compactor
    import dla_rand_pkg::*;
#(
    parameter int NUM_LANES = 12,
    parameter int SIG_WIDTH = SIG_WIDTH_DEF,
    parameter int WINDOW    = 256,
    parameter int TIMEOUT   = 1024,
    parameter logic [SIG_WIDTH-1:0] SEED = SIG_WIDTH'(SEED_DEF),
    parameter logic [SIG_WIDTH-1:0] POLY = SIG_WIDTH'(POLY_DEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [NUM_LANES-1:0] i_lanes,
    input  logic                 i_valid,
    output logic [SIG_WIDTH-1:0] o_signature,
    output logic [15:0]          o_beat_count,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    if (NUM_LANES > SIG_WIDTH) begin : g_chk_lanes
        $error("NUM_LANES must not exceed SIG_WIDTH");
    end
    if (WINDOW < 1) begin : g_chk_window
        $error("WINDOW must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_chk_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_e              state;
    logic [15:0]         count;
    logic [IDLE_W-1:0]   idle;
    logic                tmo_q;

    logic                collect;
    logic                beat;
    logic                beat_last;
    logic                idle_hit;
    logic [15:0]         count_inc;

    // Beat acceptance and run-termination decode
    always_comb begin
        collect   = (state == ST_COLLECT);
        beat      = collect && i_valid && !i_start;
        count_inc = (count == 16'hFFFF) ? count : count + 16'd1;
        beat_last = beat && (({1'b0, count} + 17'd1) == 17'(WINDOW));
        idle_hit  = collect && !i_valid && !i_start
                    && (idle == IDLE_W'(TIMEOUT - 1));
    end

    // Run FSM with beat and idle counters; start restarts from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            idle  <= '0;
            tmo_q <= 1'b0;
        end else if (i_start) begin
            state <= ST_COLLECT;
            count <= '0;
            idle  <= '0;
            tmo_q <= 1'b0;
        end else begin
            unique case (state)
                ST_COLLECT: begin
                    if (i_valid) begin
                        count <= count_inc;
                        idle  <= '0;
                        if (beat_last) begin
                            state <= ST_DONE;
                        end
                    end else begin
                        idle <= idle + IDLE_W'(1);
                        if (idle_hit) begin
                            state <= ST_DONE;
                            tmo_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    dla_misr #(
        .SIG_WIDTH (SIG_WIDTH),
        .POLY      (POLY),
        .SEED      (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (i_start),
        .step (beat),
        .data (SIG_WIDTH'(i_lanes)),
        .sig  (o_signature)
    );

    assign o_beat_count = count;
    assign o_busy       = state[0];
    assign o_done       = state[1];
    assign o_timeout    = tmo_q;

endmodule

// File: tb/tb_dla_response_compactor.sv
// Self-checking bench for dla_response_compactor: three parameter sets,
// scoreboard of expected run results popped when a run completes.
module tb_dla_response_compactor;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] cnt;
        logic        tmo;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // A: shift-only, window 4, timeout 8
    logic        a_start = 0, a_valid = 0;
    logic [11:0] a_lanes = '0;
    logic [15:0] a_sig, a_cnt;
    logic        a_busy, a_done, a_tmo;
    // B: feedback, window 1
    logic        b_start = 0, b_valid = 0;
    logic [11:0] b_lanes = '0;
    logic [15:0] b_sig, b_cnt;
    logic        b_busy, b_done, b_tmo;
    // C: default seed/poly, window 3, timeout 8
    logic        c_start = 0, c_valid = 0;
    logic [11:0] c_lanes = '0;
    logic [15:0] c_sig, c_cnt;
    logic        c_busy, c_done, c_tmo;

    dla_response_compactor #(
        .NUM_LANES(12), .SIG_WIDTH(16), .WINDOW(4), .TIMEOUT(8),
        .SEED(16'h0001), .POLY(16'h0000)
    ) u_a (
        .clk(clk), .rst(rst), .i_start(a_start), .i_lanes(a_lanes),
        .i_valid(a_valid), .o_signature(a_sig), .o_beat_count(a_cnt),
        .o_busy(a_busy), .o_done(a_done), .o_timeout(a_tmo)
    );

    dla_response_compactor #(
        .NUM_LANES(12), .SIG_WIDTH(16), .WINDOW(1), .TIMEOUT(8),
        .SEED(16'h8000)
    ) u_b (
        .clk(clk), .rst(rst), .i_start(b_start), .i_lanes(b_lanes),
        .i_valid(b_valid), .o_signature(b_sig), .o_beat_count(b_cnt),
        .o_busy(b_busy), .o_done(b_done), .o_timeout(b_tmo)
    );

    dla_response_compactor #(
        .NUM_LANES(12), .SIG_WIDTH(16), .WINDOW(3), .TIMEOUT(8)
    ) u_c (
        .clk(clk), .rst(rst), .i_start(c_start), .i_lanes(c_lanes),
        .i_valid(c_valid), .o_signature(c_sig), .o_beat_count(c_cnt),
        .o_busy(c_busy), .o_done(c_done), .o_timeout(c_tmo)
    );

    function automatic logic [15:0] model_step(
        input logic [15:0] s, input logic [11:0] d, input logic [15:0] p);
        logic [15:0] r;
        r = {s[14:0], 1'b0};
        if (s[15]) r = r ^ p;
        return r ^ {4'h0, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (c_sig !== 16'hACE1) begin
            errors++;
            $display("FAIL reset_sig got %h exp %h", c_sig, 16'hACE1);
        end
        checks++;
        if (c_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h exp 0", c_cnt);
        end
        checks++;
        if ({c_busy, c_done, c_tmo} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000",
                     {c_busy, c_done, c_tmo});
        end
        checks++;
        if (a_sig !== 16'h0001 || b_sig !== 16'h8000) begin
            errors++;
            $display("FAIL reset_seeds got %h/%h exp 0001/8000",
                     a_sig, b_sig);
        end
    endtask

    task automatic test_shift();
        logic [15:0] m;
        exp_t e;
        a_start = 1;
        tick();
        a_start = 0;
        checks++;
        if (a_busy !== 1'b1 || a_sig !== 16'h0001) begin
            errors++;
            $display("FAIL shift_start got busy=%b sig=%h exp 1/0001",
                     a_busy, a_sig);
        end
        m = 16'h0001;
        for (int k = 1; k <= 4; k++) begin
            a_valid = 1;
            a_lanes = '0;
            m = model_step(m, 12'h000, 16'h0000);
            if (k == 4) sb_q.push_back('{m, 16'd4, 1'b0});
            tick();
            if (k < 4) begin
                checks++;
                if (a_done !== 1'b0 || a_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL shift_mid%0d got done=%b busy=%b exp 0/1",
                             k, a_done, a_busy);
                end
            end
        end
        a_valid = 0;
        checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL shift_done got done=%b busy=%b exp 1/0",
                     a_done, a_busy);
        end
        e = sb_q.pop_front();
        checks++;
        if (a_sig !== e.sig || a_sig !== 16'h0010 || a_cnt !== e.cnt) begin
            errors++;
            $display("FAIL shift_sig got %h/%0d exp %h/%0d",
                     a_sig, a_cnt, e.sig, e.cnt);
        end
        a_valid = 1;
        a_lanes = 12'hFFF;
        repeat (2) tick();
        a_valid = 0;
        checks++;
        if (a_sig !== e.sig || a_cnt !== 16'd4 || a_done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold got %h/%0d/%b exp %h/4/1",
                     a_sig, a_cnt, a_done, e.sig);
        end
    endtask

    task automatic test_feedback(input logic [11:0] lanes);
        exp_t e;
        logic [15:0] m;
        b_start = 1;
        tick();
        b_start = 0;
        b_valid = 1;
        b_lanes = lanes;
        m = model_step(16'h8000, lanes, 16'hB400);
        sb_q.push_back('{m, 16'd1, 1'b0});
        tick();
        b_valid = 0;
        e = sb_q.pop_front();
        checks++;
        if (b_sig !== e.sig || b_cnt !== e.cnt) begin
            errors++;
            $display("FAIL feedback_sig lanes=%h got %h/%0d exp %h/%0d",
                     lanes, b_sig, b_cnt, e.sig, e.cnt);
        end
        checks++;
        if (b_done !== 1'b1 || b_tmo !== e.tmo) begin
            errors++;
            $display("FAIL feedback_flags got done=%b tmo=%b exp 1/%b",
                     b_done, b_tmo, e.tmo);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] m;
        exp_t e;
        logic [11:0] lv [2];
        lv[0] = 12'h0A5;
        lv[1] = 12'h100;
        a_start = 1;
        tick();
        a_start = 0;
        m = 16'h0001;
        for (int k = 0; k < 2; k++) begin
            a_valid = 1;
            a_lanes = lv[k];
            m = model_step(m, lv[k], 16'h0000);
            tick();
        end
        a_valid = 0;
        a_lanes = 12'hFFF;
        sb_q.push_back('{m, 16'd2, 1'b1});
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (a_busy !== 1'b1 || a_done !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early idle=%0d got busy=%b done=%b",
                         i, a_busy, a_done);
            end
        end
        tick();
        e = sb_q.pop_front();
        checks++;
        if (a_done !== 1'b1 || a_tmo !== e.tmo || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags got done=%b tmo=%b exp 1/1",
                     a_done, a_tmo);
        end
        checks++;
        if (a_sig !== e.sig || a_cnt !== e.cnt) begin
            errors++;
            $display("FAIL timeout_sig got %h/%0d exp %h/%0d",
                     a_sig, a_cnt, e.sig, e.cnt);
        end
        repeat (3) tick();
        checks++;
        if (a_sig !== e.sig || a_tmo !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hold got %h/%b exp %h/1",
                     a_sig, a_tmo, e.sig);
        end
    endtask

    task automatic test_restart();
        exp_t e;
        a_start = 1;
        tick();
        a_start = 0;
        checks++;
        if (a_tmo !== 1'b0) begin
            errors++;
            $display("FAIL restart_tmo_clear got %b exp 0", a_tmo);
        end
        a_valid = 1;
        a_lanes = 12'h00F;
        repeat (2) tick();
        a_start = 1;
        a_lanes = 12'hFFF;
        tick();
        a_start = 0;
        checks++;
        if (a_sig !== 16'h0001 || a_cnt !== 16'd0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart got sig=%h cnt=%0d busy=%b exp 0001/0/1",
                     a_sig, a_cnt, a_busy);
        end
        a_lanes = 12'h000;
        sb_q.push_back('{16'h0010, 16'd4, 1'b0});
        repeat (4) tick();
        a_valid = 0;
        e = sb_q.pop_front();
        checks++;
        if (a_done !== 1'b1 || a_sig !== e.sig || a_cnt !== e.cnt) begin
            errors++;
            $display("FAIL restart_run got done=%b sig=%h cnt=%0d exp 1/%h/%0d",
                     a_done, a_sig, a_cnt, e.sig, e.cnt);
        end
    endtask

    task automatic test_reset_gapped();
        logic [15:0] m;
        logic [11:0] d;
        exp_t e;
        int wait_cyc;
        c_start = 1;
        tick();
        c_start = 0;
        c_valid = 1;
        c_lanes = 12'h123;
        repeat (2) tick();
        rst = 1;
        tick();
        rst = 0;
        c_valid = 0;
        checks++;
        if (c_sig !== 16'hACE1 || c_cnt !== 16'd0
            || {c_busy, c_done, c_tmo} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset got sig=%h cnt=%0d flags=%b",
                     c_sig, c_cnt, {c_busy, c_done, c_tmo});
        end
        c_start = 1;
        tick();
        c_start = 0;
        m = 16'hACE1;
        for (int c = 1; c <= 6; c++) begin
            d = 12'($urandom);
            c_lanes = d;
            c_valid = (c == 1 || c == 4 || c == 6);
            if (c_valid) m = model_step(m, d, 16'hB400);
            if (c == 6) sb_q.push_back('{m, 16'd3, 1'b0});
            tick();
            if (c < 6) begin
                checks++;
                if (c_done !== 1'b0) begin
                    errors++;
                    $display("FAIL gapped_early c=%0d got done=%b exp 0",
                             c, c_done);
                end
            end
        end
        c_valid = 0;
        wait_cyc = 0;
        while (c_done !== 1'b1 && wait_cyc < 20) begin
            tick();
            wait_cyc++;
        end
        e = sb_q.pop_front();
        checks++;
        if (c_done !== 1'b1 || wait_cyc != 0) begin
            errors++;
            $display("FAIL gapped_done got done=%b after %0d extra cycles",
                     c_done, wait_cyc);
        end
        checks++;
        if (c_sig !== e.sig || c_cnt !== e.cnt || c_tmo !== e.tmo) begin
            errors++;
            $display("FAIL gapped_sig got %h/%0d/%b exp %h/%0d/%b",
                     c_sig, c_cnt, c_tmo, e.sig, e.cnt, e.tmo);
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_feedback(12'h003);
        test_feedback(12'hFFF);
        test_timeout();
        test_restart();
        test_reset_gapped();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
